// File: rtl/zoom_replicacao_param.sv
// Nearest-neighbour pixel replication upscaler: buffers one input row and replays it F times, each pixel F wide (F in 1,2,4).
// Latency: first output pixel valid two cycles after the last pixel of an input row is accepted.
// Backpressure: out_ready low freezes the output register; in_ready only high while a row is loading.
module zoom_replicacao_param #(
  parameter int DATA_W = 8,
  parameter int W_IN   = 160,
  parameter int H_IN   = 120
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        fator,
  input  logic [DATA_W-1:0] in_pixel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_pixel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_eol,
  output logic              out_eof,
  output logic              busy,
  output logic              done
);

  localparam int COL_W  = $clog2(W_IN);
  localparam int ROW_W  = (H_IN > 1) ? $clog2(H_IN) : 1;
  localparam int OCOL_W = $clog2(W_IN * 4);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(W_IN - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(H_IN - 1);

  typedef enum logic [1:0] {IDLE, LOAD, EMIT, FIN} state_t;

  state_t              state;
  logic [1:0]          f_shift;   // log2 of the latched factor
  logic [COL_W-1:0]    in_col;
  logic [ROW_W-1:0]    in_row;
  logic [OCOL_W-1:0]   out_col;   // position of the pixel currently held in the output register
  logic [1:0]          rep_v;
  logic [DATA_W-1:0]   line_buf [W_IN];

  logic [OCOL_W-1:0]   ocol_last;
  logic [1:0]          rep_last;
  logic                row_wrap;
  logic                line_done;
  logic [OCOL_W-1:0]   ld_col;
  logic [1:0]          ld_rep;
  logic                ld_eol;
  logic                ld_eof;
  logic [COL_W-1:0]    rd_idx;

  assign ocol_last = OCOL_W'((W_IN << f_shift) - 1);
  assign rep_last  = 2'((1 << f_shift) - 1);

  // Position of the next pixel to load into the output register; position 0 when the register is empty.
  always_comb begin
    row_wrap  = (out_col == ocol_last);
    line_done = row_wrap && (rep_v == rep_last);
    ld_col    = out_col;
    ld_rep    = rep_v;
    if (out_valid) begin
      ld_col = row_wrap ? '0 : out_col + 1'b1;
      ld_rep = row_wrap ? rep_v + 2'd1 : rep_v;
    end
    ld_eol = (ld_col == ocol_last);
    ld_eof = ld_eol && (ld_rep == rep_last) && (in_row == ROW_LAST);
    rd_idx = COL_W'(ld_col >> f_shift);
  end

  // Line buffer fill; written only on accepted input transfers.
  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      line_buf[in_col] <= in_pixel;
    end
  end

  // Control FSM with registered handshake, flag and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      f_shift   <= 2'd0;
      in_col    <= '0;
      in_row    <= '0;
      out_col   <= '0;
      rep_v     <= 2'd0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (fator)
              2'b01:   f_shift <= 2'd1;
              2'b10:   f_shift <= 2'd2;
              default: f_shift <= 2'd0;
            endcase
            in_col   <= '0;
            in_row   <= '0;
            out_col  <= '0;
            rep_v    <= 2'd0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (in_col == COL_LAST) begin
              in_col   <= '0;
              in_ready <= 1'b0;
              state    <= EMIT;
            end else begin
              in_col <= in_col + 1'b1;
            end
          end
        end
        EMIT: begin
          if (!out_valid || out_ready) begin
            if (out_valid && line_done) begin
              out_valid <= 1'b0;
              out_eol   <= 1'b0;
              out_eof   <= 1'b0;
              out_col   <= '0;
              rep_v     <= 2'd0;
              if (in_row != ROW_LAST) begin
                in_row   <= in_row + 1'b1;
                in_ready <= 1'b1;
                state    <= LOAD;
              end else begin
                done  <= 1'b1;
                state <= FIN;
              end
            end else begin
              out_valid <= 1'b1;
              out_col   <= ld_col;
              rep_v     <= ld_rep;
              out_pixel <= line_buf[rd_idx];
              out_eol   <= ld_eol;
              out_eof   <= ld_eof;
            end
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zoom_replicacao_param.sv
module tb_zoom_replicacao_param;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  typedef struct packed {
    logic [DW-1:0] pix;
    logic          eol;
    logic          eof;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    fator = 2'b00;
  logic [DW-1:0] in_pixel = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_pixel;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_eol;
  logic          out_eof;
  logic          busy;
  logic          done;

  int  checks = 0;
  int  errors = 0;
  exp_t sb[$];
  bit  rdy_rand = 0;
  bit  abort = 0;
  bit  done_seen = 0;
  int  accepted = 0;

  zoom_replicacao_param #(.DATA_W(DW), .W_IN(W), .H_IN(H)) dut (
    .clk(clk), .reset(rst), .start(start), .fator(fator),
    .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
    .out_pixel(out_pixel), .out_valid(out_valid), .out_ready(out_ready),
    .out_eol(out_eol), .out_eof(out_eof), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream ready: always 1 or a 50% coin flip per cycle.
  initial forever begin
    @(posedge clk); #1;
    out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops the scoreboard on every accepted output, checks stall stability and the done pulse.
  initial begin
    bit            prev_stall = 0;
    bit            expect_done = 0;
    logic [DW-1:0] p_pix = '0;
    logic          p_eol = 0, p_eof = 0;
    exp_t          e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
        expect_done = 0;
        continue;
      end
      if (done || expect_done) chk("done_pulse", {31'd0, done}, {31'd0, expect_done});
      if (done) done_seen = 1;
      expect_done = 0;
      if (prev_stall && out_valid) begin
        chk("stall_hold", {22'd0, out_pixel, out_eol, out_eof}, {22'd0, p_pix, p_eol, p_eof});
      end
      if (out_valid && out_ready) begin
        accepted++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_output: got pixel %0d with no expected pixel left", out_pixel);
        end else begin
          e = sb.pop_front();
          chk("out_pixel", {24'd0, out_pixel}, {24'd0, e.pix});
          chk("out_flags", {30'd0, out_eol, out_eof}, {30'd0, e.eol, e.eof});
          if (e.eof) expect_done = 1;
        end
      end
      prev_stall = out_valid && !out_ready;
      p_pix = out_pixel;
      p_eol = out_eol;
      p_eof = out_eof;
    end
  end

  // Issues one frame: pushes the reference output, pulses start, feeds pixels, waits for done.
  task automatic run_frame(input logic [1:0] fsel, input bit gaps, input bit rnd_pix, input bit inject);
    logic [DW-1:0] pix [W*H];
    int f, idx, cyc;
    exp_t e;
    for (int i = 0; i < W*H; i++) pix[i] = rnd_pix ? DW'($urandom) : DW'(i);
    f = (fsel == 2'b01) ? 2 : (fsel == 2'b10) ? 4 : 1;
    // Output row r*f+rv repeats input row r; output column c shows input column c/f.
    for (int r = 0; r < H; r++)
      for (int rv = 0; rv < f; rv++)
        for (int c = 0; c < W*f; c++) begin
          e.pix = pix[r*W + c/f];
          e.eol = (c == W*f - 1);
          e.eof = e.eol && (rv == f - 1) && (r == H - 1);
          sb.push_back(e);
        end
    done_seen = 0;
    @(posedge clk); #1;
    fator = fsel;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < W*H && !abort) begin
      @(posedge clk); #1;
      cyc++;
      if (inject) begin
        start = (cyc == 20);
        fator = (cyc == 20) ? 2'b10 : fsel;
      end
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_pixel = pix[idx];
      end
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      if (cyc > 4000) begin
        chk("input_timeout", 32'(idx), 32'(W*H));
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    start = 1'b0;
    if (!abort) begin
      cyc = 0;
      while (!done_seen && cyc < 4000) begin
        @(negedge clk);
        cyc++;
      end
      chk("frame_done", {31'd0, done_seen}, 32'd1);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      @(posedge clk); #1;
      chk("idle_busy", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    int base, cyc;
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
    chk("rst_out_pixel", {22'd0, out_pixel, out_eol, out_eof}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_frame(2'b01, 0, 0, 0);   // 2x, 64 outputs
    run_frame(2'b00, 0, 0, 0);   // 1x, 16 outputs
    run_frame(2'b11, 0, 0, 0);   // reserved, behaves as 1x
    run_frame(2'b10, 0, 0, 0);   // 4x, 256 outputs
    rdy_rand = 1;
    run_frame(2'b01, 1, 0, 0);   // gaps on both sides
    run_frame(2'b10, 1, 1, 0);   // random pixels, 4x
    run_frame(2'b00, 1, 1, 0);
    rdy_rand = 0;
    run_frame(2'b01, 0, 0, 1);   // second start mid-frame must be ignored

    // Reset in the middle of emitting input row 2.
    base = accepted;
    fork
      run_frame(2'b01, 0, 0, 0);
      begin
        cyc = 0;
        while (accepted < base + 36 && cyc < 3000) begin
          @(negedge clk);
          cyc++;
        end
        chk("reach_row2", {31'd0, accepted >= base + 36}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        abort = 1;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_busy", {30'd0, busy, done}, 32'd0);
        chk("mid_rst_outs", {21'd0, out_pixel, out_eol, out_eof, in_ready}, 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
      end
    join
    abort = 0;
    run_frame(2'b01, 0, 0, 0);   // clean frame after reset

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/zoom_replicacao_param.md
Name: zoom_replicacao_param

Overview:
Parametrised nearest-neighbour (pixel replication) upscaler for the grayscale image pipeline. Takes a row-major input frame of W_IN x H_IN pixels over a valid/ready stream and emits a (W_IN*F) x (H_IN*F) frame, with runtime factor F in {1,2,4}. Sits between the image ROM/source reader and the display/output writer. Supersedes the fixed 2x replication path in escolha_algoritmo and adds backpressure, runtime factor selection and frame start/done control.

Parameters:
DATA_W, 8, pixel width in bits
W_IN, 160, input frame width in pixels (>=2)
H_IN, 120, input frame height in pixels (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a frame when in IDLE, ignored otherwise
fator  in  2  scale select, sampled on accepted start: 00=1, 01=2, 10=4, 11=reserved (treated as 1)
in_pixel  in  DATA_W  input pixel
in_valid  in  1  in_pixel valid
in_ready  out  1  block accepts in_pixel this cycle
out_pixel  out  DATA_W  replicated output pixel
out_valid  out  1  out_pixel valid
out_ready  in  1  downstream accepts out_pixel this cycle
out_eol  out  1  qualifies last pixel of an output row (valid with out_valid)
out_eof  out  1  qualifies last pixel of the output frame
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after last output pixel is accepted

Behaviour:
- Reset (async, any time, incl. mid-frame): state=IDLE; in_ready, out_valid, out_eol, out_eof, busy, done = 0; out_pixel = 0; all counters = 0; latched factor = 1. Partial frame is discarded; next frame needs new start.
- Storage: one line buffer of W_IN x DATA_W. Counters: in_col (0..W_IN-1), in_row (0..H_IN-1), out_col (0..W_IN*F-1), rep_v (0..F-1).
- FSM:
  - IDLE: start=1 -> latch F, clear counters, go LOAD.
  - LOAD: in_ready=1. Transfer = in_valid & in_ready -> buf[in_col] <= in_pixel, in_col++. Transfer at in_col=W_IN-1 -> in_col=0, go EMIT next cycle. in_valid gaps stall; no timeout.
  - EMIT: in_ready=0; out_valid=1 continuously; out_pixel = buf[out_col >> log2(F)] (registered). Transfer = out_valid & out_ready -> out_col++. At out_col=W_IN*F-1: out_col=0; if rep_v<F-1 -> rep_v++, stay in EMIT; else rep_v=0 and either (in_row<H_IN-1) in_row++, go LOAD, or go FIN.
  - FIN: done=1 for exactly one cycle, then IDLE.
- Output register stability: while out_valid=1 and out_ready=0, out_pixel, out_eol, out_eof hold unchanged. No bubble between consecutive output pixels within EMIT under continuous out_ready.
- out_eol=1 when out_col=W_IN*F-1; out_eof=1 when additionally rep_v=F-1 and in_row=H_IN-1.
- Latency: first out_valid asserts in the 2nd cycle after the last input pixel of a row is accepted (LOAD->EMIT transition plus buffer read register). Input and output phases do not overlap.
- Counts: exactly W_IN*H_IN input transfers and W_IN*H_IN*F*F output transfers per frame.
- start while busy=1 ignored; fator changes mid-frame ignored.
- in_valid during IDLE/EMIT/FIN is not consumed (in_ready=0).

Test Plan:
- W_IN=4,H_IN=4, input 0..15, fator=01, out_ready=1 -> 64 outputs; row0 and row1 both "0 0 1 1 2 2 3 3", row7 "12 12 13 13 14 14 15 15"; out_eol on every 8th pixel, out_eof on 64th; done one cycle later.
- Same frame, fator=00 and fator=11 -> 16 outputs equal to 0..15 in order; out_eol every 4th.
- Same frame, fator=10 -> 256 outputs; output row 0..3 each "0 0 0 0 1 1 1 1 2 2 2 2 3 3 3 3"; out_eof on 256th only.
- fator=01, out_ready random 50% and in_valid random gaps -> identical 64-pixel sequence, out_pixel/out_eol stable during out_ready=0 stalls, no duplicates or drops.
- Assert reset for 1 cycle mid-EMIT of row 2 -> all outputs 0 same cycle, busy=0; new start runs a clean full frame from pixel 0.
- Second start pulse during busy with fator=10 -> ignored; current frame completes at factor 2 with 64 outputs.
